// File: rtl/mem_access_if.sv
// Data bus between the MEM stage and the data memory: req/ack handshake
// with byte enables. The stage is the master, the memory the slave.
interface mem_access_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output ack, rdata
    );
endinterface

// File: rtl/mem_access.sv
// HYmips MEM stage: issues loads/stores on the data bus, formats sub-word
// load/store data, flags misaligned addresses and stalls the pipeline
// while a bus access is outstanding.
module mem_access (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       stop,
    input  logic [4:0]       wd_i,
    input  logic             wreg_i,
    input  logic [31:0]      wdata_i,
    input  logic [3:0]       memop_i,
    input  logic [31:0]      memaddr_i,
    input  logic [31:0]      memdata_i,
    output logic [4:0]       mem_wd,
    output logic             mem_wreg,
    output logic [31:0]      mem_wdata,
    output logic             stallreq,
    mem_access_if.master     dbus,
    output logic             exc_adel,
    output logic             exc_ades,
    output logic [31:0]      exc_badvaddr
);

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] rdata_q;

    logic        is_load;
    logic        is_store;
    logic        misalign;
    logic        mem_op;
    logic [1:0]  lane;
    logic        req;
    logic        stall;
    logic        capture;
    logic [31:0] load_word;
    logic [31:0] shifted;
    logic [31:0] load_data;
    logic [3:0]  be;
    logic [31:0] store_data;
    logic        unused_stop;

    assign unused_stop = ^{stop[5], stop[3:0]};
    assign lane        = memaddr_i[1:0];

    // Decode the operation class and check address alignment.
    always_comb begin
        is_load  = (memop_i >= OP_LB) && (memop_i <= OP_LW);
        is_store = (memop_i >= OP_SB) && (memop_i <= OP_SW);
        misalign = 1'b0;
        case (memop_i)
            OP_LH, OP_LHU, OP_SH: misalign = lane[0];
            OP_LW, OP_SW:         misalign = (lane != 2'b00);
            default:              misalign = 1'b0;
        endcase
        mem_op = (is_load || is_store) && !misalign;
    end

    // State register and captured read word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            rdata_q <= '0;
        end else begin
            state <= state_next;
            if (capture) begin
                rdata_q <= dbus.rdata;
            end
        end
    end

    // Next-state and handshake control.
    // The word is captured on every accepted ack, including a zero-wait ack
    // in IDLE that moves to DONE because the stage is held: DONE always
    // reads rdata_q, so it must be valid on both entry paths.
    always_comb begin
        state_next = state;
        req        = 1'b0;
        stall      = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (mem_op) begin
                    req = 1'b1;
                    if (dbus.ack) begin
                        capture = 1'b1;
                        if (stop[4]) begin
                            state_next = DONE;
                        end
                    end else begin
                        stall      = 1'b1;
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                req   = 1'b1;
                stall = 1'b1;
                if (dbus.ack) begin
                    capture    = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (!stop[4]) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Load lane selection and sign/zero extension.
    always_comb begin
        load_word = (state == DONE) ? rdata_q : dbus.rdata;
        shifted   = load_word >> {lane, 3'b000};
        load_data = load_word;
        case (memop_i)
            OP_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
            OP_LBU:  load_data = {24'h000000, shifted[7:0]};
            OP_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
            OP_LHU:  load_data = {16'h0000, shifted[15:0]};
            default: load_data = load_word;
        endcase
    end

    // Byte enables and replicated store data.
    always_comb begin
        be         = 4'b0000;
        store_data = '0;
        if (mem_op) begin
            case (memop_i)
                OP_SB: begin
                    be         = 4'b0001 << lane;
                    store_data = {4{memdata_i[7:0]}};
                end
                OP_SH: begin
                    be         = lane[1] ? 4'b1100 : 4'b0011;
                    store_data = {2{memdata_i[15:0]}};
                end
                OP_SW: begin
                    be         = 4'b1111;
                    store_data = memdata_i;
                end
                default: be = 4'b1111;
            endcase
        end
    end

    // Output drive; everything is forced low while reset is asserted.
    always_comb begin
        mem_wd       = '0;
        mem_wreg     = 1'b0;
        mem_wdata    = '0;
        stallreq     = 1'b0;
        dbus.req     = 1'b0;
        dbus.we      = 1'b0;
        dbus.addr    = '0;
        dbus.be      = '0;
        dbus.wdata   = '0;
        exc_adel     = 1'b0;
        exc_ades     = 1'b0;
        exc_badvaddr = '0;
        if (!rst) begin
            mem_wd     = wd_i;
            mem_wreg   = misalign ? 1'b0 : wreg_i;
            mem_wdata  = (is_load && !misalign) ? load_data : wdata_i;
            stallreq   = stall;
            dbus.req   = req;
            dbus.we    = req && is_store;
            dbus.addr  = {memaddr_i[31:2], 2'b00};
            dbus.be    = be;
            dbus.wdata = store_data;
            exc_adel   = misalign && is_load;
            exc_ades   = misalign && is_store;
            if (misalign) begin
                exc_badvaddr = memaddr_i;
            end
        end
    end

endmodule
